adder: RTL and testbench
========================

Name: adder

Overview:
- Parameterised two's-complement adder/subtractor with a registered result.
- Mode input `m` selects the operation: a+b when m=0, a-b when m=1.
- Reports the N-bit result, the carry-out of the MSB, and signed overflow.
- Used as the arithmetic datapath leaf. Latency is one clock, with a valid strobe alongside the result.

Parameters:
- WIDTH, 4, operand and result width in bits (must be ≥2).

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  operands and mode are sampled on any clk edge where this is 1.
- a  input  WIDTH  first operand (num1).
- b  input  WIDTH  second operand (num2).
- m  input  1  mode: 0 = add, 1 = subtract (a - b).
- out_valid  output  1  high for exactly one cycle per accepted operation.
- sum  output  WIDTH  registered result, modulo 2^WIDTH.
- c_out  output  1  registered carry out of the MSB stage.
- overflow  output  1  registered signed (two's-complement) overflow flag.

Behaviour:
- Datapath is a ripple chain of WIDTH full adders.
  - Stage i inputs: a[i], b[i] XOR m, and the carry from stage i-1.
  - The carry into stage 0 is m.
  - Subtraction is therefore a + ~b + 1.
- sum = low WIDTH bits of the chain result.
- c_out = carry out of stage WIDTH-1.
  - In subtract mode, c_out=1 means no borrow (a ≥ b unsigned).
  - c_out=0 means a borrow occurred.
- overflow = carry into stage WIDTH-1 XOR carry out of stage WIDTH-1.
  - Equivalently: the signs of a and the effective b (b XOR m) match, and the sign of sum differs from them.
- Latency:
  - Inputs are sampled at edge k when in_valid=1.
  - sum, c_out, overflow and out_valid update at that same edge k.
  - The new values are visible during cycle k+1.
- When in_valid=0 at an edge:
  - out_valid goes to 0.
  - sum, c_out and overflow hold their previous values.
- Back-to-back operations are accepted every cycle; there is no backpressure.
- Reset (rst=1 at a clk edge):
  - sum=0, c_out=0, overflow=0, out_valid=0.
  - Reset has priority over in_valid on the same edge; that operation is dropped.
  - Reset asserted between operations discards the last result. Outputs read 0 from the next cycle.
- No combinational path from inputs to outputs. All outputs come straight from flops.
- Boundary cases:
  - a - 0 with m=1 gives sum=a, c_out=1, overflow=0.
  - Most-negative minus 1 overflows.
  - Most-positive plus 1 overflows.
  - 0 - 0 gives sum=0, c_out=1.

Optional Feature:
- Macro: ADDER_STICKY_OVF_EN.
- When defined:
  - Adds output ovf_sticky (1 bit), a registered flag that sets on any accepted operation producing overflow=1.
  - It stays set until rst; only reset clears it.
  - It sets in the same cycle that overflow first reads 1.
- When not defined:
  - The port and its flop do not exist.
  - Behaviour is otherwise identical.

Test Plan:
- rst=1 for 2 cycles, then released, with in_valid=0 → sum=0, c_out=0, overflow=0, out_valid=0.
- a=0, b=0, m=0, in_valid=1 → next cycle: sum=0000, c_out=0, overflow=0, out_valid=1.
- a=3, b=5, m=0 → sum=1000 (8), c_out=0, overflow=1 (3+5 exceeds +7). With ADDER_STICKY_OVF_EN, ovf_sticky=1.
- a=7, b=1, m=1 → sum=0110 (6), c_out=1, overflow=0.
- a=1000 (-8), b=1, m=1 → sum=0111, c_out=1, overflow=1. Then one cycle with in_valid=0 → out_valid=0, sum holds 0111.
- Apply in_valid=1 (a=3, b=5, m=0) and rst=1 on the same edge → all outputs 0 next cycle. ovf_sticky (if present) clears to 0.

Source files
------------

// File: rtl/adder_if.sv
// ============================================================================
// Module   : adder_if
// Brief    : Operand/result bundle for the adder. ADDER_STICKY_OVF_EN adds ovf_sticky.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
`ifdef ADDER_STICKY_OVF_EN
    logic             ovf_sticky;
`endif

    modport master (
        output in_valid, a, b, m,
        input  out_valid, sum, c_out, overflow
`ifdef ADDER_STICKY_OVF_EN
        , input ovf_sticky
`endif
    );

    modport slave (
        input  in_valid, a, b, m,
        output out_valid, sum, c_out, overflow
`ifdef ADDER_STICKY_OVF_EN
        , output ovf_sticky
`endif
    );
endinterface

`default_nettype wire

// File: rtl/adder.sv
// ============================================================================
// Module   : adder
// Brief    : Registered ripple-carry adder/subtractor (m=1 gives a - b), 1-cycle
//            latency. Optional sticky overflow flag via ADDER_STICKY_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder #(
    parameter int WIDTH = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    adder_if.slave    bus
);
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_overflow;

    // Carry-in equal to m completes the two's-complement negation of b.
    assign w_carry[0] = bus.m;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage
            assign w_b_eff[i]   = bus.b[i] ^ bus.m;
            assign w_sum[i]     = bus.a[i] ^ w_b_eff[i] ^ w_carry[i];
            assign w_carry[i+1] = (bus.a[i] & w_b_eff[i]) |
                                  (w_carry[i] & (bus.a[i] ^ w_b_eff[i]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum      <= w_sum;
                r_c_out    <= w_carry[WIDTH];
                r_overflow <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.c_out     = r_c_out;
    assign bus.overflow  = r_overflow;

`ifdef ADDER_STICKY_OVF_EN
    logic r_ovf_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (bus.in_valid && (w_carry[WIDTH] ^ w_carry[WIDTH-1])) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign bus.ovf_sticky = r_ovf_sticky;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder.sv
// ============================================================================
// Module   : tb_adder
// Brief    : Directed self-checking bench for the 4-bit adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   fails;

    adder_if #(.WIDTH(WIDTH)) bus ();

    adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, let one rising edge pass, sample 1ns later.
    task automatic step(input logic v, input logic [3:0] aa, input logic [3:0] bb,
                        input logic mm, input logic rr);
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = aa;
        bus.b        = bb;
        bus.m        = mm;
        rst          = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        vectors++;
        if ({bus.out_valid, bus.c_out, bus.overflow, bus.sum} !== 7'b0) begin
            fails++;
            $display("FAIL reset_state: got v=%b c=%b o=%b sum=%h, want all 0",
                     bus.out_valid, bus.c_out, bus.overflow, bus.sum);
        end
`ifdef ADDER_STICKY_OVF_EN
        vectors++;
        if (bus.ovf_sticky !== 1'b0) begin
            fails++;
            $display("FAIL reset_sticky: got %b, want 0", bus.ovf_sticky);
        end
`endif
    endtask

    // Each row: a, b, m, expected {c_out, overflow, sum}
    task automatic test_add_sub;
        logic [3:0] ta [6] = '{4'h0, 4'h3, 4'h7, 4'h8, 4'h5, 4'h7};
        logic [3:0] tb [6] = '{4'h0, 4'h5, 4'h1, 4'h1, 4'h0, 4'h1};
        logic       tm [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [5:0] te [6] = '{6'b00_0000, 6'b01_1000, 6'b10_0110,
                               6'b11_0111, 6'b10_0101, 6'b01_1000};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, ta[i], tb[i], tm[i], 1'b0);
            vectors++;
            if ({bus.out_valid, bus.c_out, bus.overflow, bus.sum} !== {1'b1, te[i]}) begin
                fails++;
                $display("FAIL add_sub[%0d] a=%h b=%h m=%b: got v=%b c=%b o=%b sum=%h, want v=1 c=%b o=%b sum=%h",
                         i, ta[i], tb[i], tm[i], bus.out_valid, bus.c_out, bus.overflow,
                         bus.sum, te[i][5], te[i][4], te[i][3:0]);
            end
`ifdef ADDER_STICKY_OVF_EN
            vectors++;
            if (bus.ovf_sticky !== (i >= 1)) begin
                fails++;
                $display("FAIL sticky[%0d]: got %b, want %b", i, bus.ovf_sticky, (i >= 1));
            end
`endif
        end
    endtask

    task automatic test_hold;
        step(1'b1, 4'h8, 4'h1, 1'b1, 1'b0);
        step(1'b0, 4'h2, 4'h2, 1'b0, 1'b0);
        vectors++;
        if ({bus.out_valid, bus.c_out, bus.overflow, bus.sum} !== 7'b0_11_0111) begin
            fails++;
            $display("FAIL hold_idle: got v=%b c=%b o=%b sum=%h, want v=0 c=1 o=1 sum=7",
                     bus.out_valid, bus.c_out, bus.overflow, bus.sum);
        end
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        vectors++;
        if ({bus.out_valid, bus.c_out, bus.overflow, bus.sum} !== 7'b0_11_0111) begin
            fails++;
            $display("FAIL hold_idle2: got v=%b c=%b o=%b sum=%h, want v=0 c=1 o=1 sum=7",
                     bus.out_valid, bus.c_out, bus.overflow, bus.sum);
        end
    endtask

    // Each row: a, b, m, expected {c_out, overflow, sum}; one op per cycle.
    task automatic test_back_to_back;
        logic [3:0] ta [5] = '{4'h0, 4'h2, 4'hF, 4'h4, 4'h7};
        logic [3:0] tb [5] = '{4'h0, 4'h3, 4'h1, 4'h6, 4'hF};
        logic       tm [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [5:0] te [5] = '{6'b10_0000, 6'b00_0101, 6'b10_0000,
                               6'b00_1110, 6'b01_1000};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ta[i], tb[i], tm[i], 1'b0);
            vectors++;
            if ({bus.out_valid, bus.c_out, bus.overflow, bus.sum} !== {1'b1, te[i]}) begin
                fails++;
                $display("FAIL b2b[%0d] a=%h b=%h m=%b: got v=%b c=%b o=%b sum=%h, want v=1 c=%b o=%b sum=%h",
                         i, ta[i], tb[i], tm[i], bus.out_valid, bus.c_out, bus.overflow,
                         bus.sum, te[i][5], te[i][4], te[i][3:0]);
            end
        end
    endtask

    task automatic test_reset_priority;
        step(1'b1, 4'h3, 4'h5, 1'b0, 1'b1);
        vectors++;
        if ({bus.out_valid, bus.c_out, bus.overflow, bus.sum} !== 7'b0) begin
            fails++;
            $display("FAIL reset_priority: got v=%b c=%b o=%b sum=%h, want all 0",
                     bus.out_valid, bus.c_out, bus.overflow, bus.sum);
        end
`ifdef ADDER_STICKY_OVF_EN
        vectors++;
        if (bus.ovf_sticky !== 1'b0) begin
            fails++;
            $display("FAIL reset_priority_sticky: got %b, want 0", bus.ovf_sticky);
        end
`endif
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        vectors++;
        if ({bus.out_valid, bus.c_out, bus.overflow, bus.sum} !== 7'b0) begin
            fails++;
            $display("FAIL after_reset_idle: got v=%b c=%b o=%b sum=%h, want all 0",
                     bus.out_valid, bus.c_out, bus.overflow, bus.sum);
        end
    endtask

    initial begin
        vectors      = 0;
        fails        = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.m        = 1'b0;
        test_reset();
        test_add_sub();
        test_hold();
        test_back_to_back();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

`default_nettype wire
